// File: rtl/p22_map_store_if.sv
// Map store bus: overlay port, tracer req/ack port, loader write port.
// master drives addresses/requests/writes; slave (the store) answers.
interface p22_map_store_if #(
  parameter int MAP_WBITS = 4,
  parameter int MAP_HBITS = 4
);
  logic                 ov_active;
  logic [MAP_WBITS-1:0] ov_col;
  logic [MAP_HBITS-1:0] ov_row;
  logic [1:0]           ov_val;

  logic                 tr_req;
  logic [MAP_WBITS-1:0] tr_col;
  logic [MAP_HBITS-1:0] tr_row;
  logic                 tr_ack;
  logic [1:0]           tr_val;

  logic                 wr_en;
  logic [MAP_WBITS-1:0] wr_col;
  logic [MAP_HBITS-1:0] wr_row;
  logic [1:0]           wr_val;

  logic [7:0]           tr_wait_cnt;

  modport master (
    output ov_active, ov_col, ov_row,
    output tr_req, tr_col, tr_row,
    output wr_en, wr_col, wr_row, wr_val,
    input  ov_val, tr_ack, tr_val,
    input  tr_wait_cnt
  );

  modport slave (
    input  ov_active, ov_col, ov_row,
    input  tr_req, tr_col, tr_row,
    input  wr_en, wr_col, wr_row, wr_val,
    output ov_val, tr_ack, tr_val,
    output tr_wait_cnt
  );
endinterface

// File: rtl/p22_map_store.sv
// Map store: 2-bit wall grid, combinational overlay read, req/ack tracer
// read (overlay has priority), single-cell writes. Ports: clk, rst_n, bus.
module p22_map_store #(
  parameter int MAP_WBITS = 4,
  parameter int MAP_HBITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  p22_map_store_if.slave bus
);

  localparam int W = 1 << MAP_WBITS;
  localparam int H = 1 << MAP_HBITS;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACK  = 1'b1;

  logic [1:0] cell_q [H][W];

  logic [0:0] state_q, state_d;
  logic [1:0] tr_val_q, tr_val_d;
  logic [7:0] cnt_q, cnt_d;

  logic idle;
  logic grant;
  logic blocked;

  assign idle    = (state_q == S_IDLE);
  assign grant   = idle && bus.tr_req && !bus.ov_active;
  assign blocked = idle && bus.tr_req && bus.ov_active;

  // Registers make the overlay read naturally read-before-write.
  assign bus.ov_val      = cell_q[bus.ov_row][bus.ov_col];
  assign bus.tr_ack      = (state_q == S_ACK);
  assign bus.tr_val      = tr_val_q;
  assign bus.tr_wait_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          if (r == 0 || r == H - 1 || c == 0 || c == W - 1)
            cell_q[r][c] <= 2'd1;
          else
            cell_q[r][c] <= 2'd0;
        end
      end
    end else if (bus.wr_en) begin
      cell_q[bus.wr_row][bus.wr_col] <= bus.wr_val;
    end
  end

  always_comb begin
    state_d  = state_q;
    tr_val_d = tr_val_q;
    cnt_d    = cnt_q;
    unique case (1'b1)
      (state_q == S_ACK): begin
        state_d = S_IDLE;
      end
      grant: begin
        state_d  = S_ACK;
        tr_val_d = cell_q[bus.tr_row][bus.tr_col];
      end
      blocked: begin
        if (cnt_q != 8'hFF)
          cnt_d = cnt_q + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tr_val_q <= 2'd0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      tr_val_q <= tr_val_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: doc/p22_map_store.md
Name: p22_map_store

Overview:
- Map memory responder for raybox-zero.
- Holds the 2^MAP_WBITS x 2^MAP_HBITS grid of 2-bit wall IDs.
- Serves two readers:
  - map overlay: combinational, same-cycle port with absolute priority.
  - tracer: registered req/ack port, granted only while the overlay is not drawing.
- Also accepts synchronous single-cell writes from the map loader.

Parameters:
- MAP_WBITS, 4: map column index width; map width = 1<<MAP_WBITS.
- MAP_HBITS, 4: map row index width; map height = 1<<MAP_HBITS.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- ov_active  in  1  overlay is inside its screen region and owns the map this cycle.
- ov_col  in  MAP_WBITS  overlay column address.
- ov_row  in  MAP_HBITS  overlay row address.
- ov_val  out  2  wall ID at (ov_col, ov_row); combinational.
- tr_req  in  1  tracer read request, level.
- tr_col  in  MAP_WBITS  tracer column address.
- tr_row  in  MAP_HBITS  tracer row address.
- tr_ack  out  1  one-cycle pulse: tr_val is valid for the granted request.
- tr_val  out  2  registered wall ID for the last granted tracer request.
- wr_en  in  1  write strobe.
- wr_col  in  MAP_WBITS  write column.
- wr_row  in  MAP_HBITS  write row.
- wr_val  in  2  wall ID to write.
- tr_wait_cnt  out  8  saturating count of tracer cycles blocked by the overlay.

Behaviour:
- Storage: one 2-bit register per cell. No RAM macro.
- Reset state (rst_n low, asynchronous):
  - Border cells (col 0, col max, row 0, row max) = 1; all other cells = 0.
  - tr_ack = 0, tr_val = 0, tr_wait_cnt = 0, FSM = IDLE.
  - Reset asserted mid-transaction aborts it: no ack is issued; the requester must re-request.
- Write:
  - wr_en = 1 at a clock edge updates cell[wr_row][wr_col] with wr_val.
  - The new value is visible on ov_val and to tracer grants from the following cycle.
  - Writes are never blocked by ov_active or the FSM.
- Overlay read:
  - ov_val = cell[ov_row][ov_col], purely combinational, independent of ov_active.
  - On a same-cycle write to the same cell, ov_val shows the old value (read-before-write).
- Tracer FSM, two states:
  - IDLE:
    - If tr_req = 1 and ov_active = 0: grant. At the edge, tr_val <= cell[tr_row][tr_col] (pre-write value on a collision) and FSM goes to ACK.
    - If tr_req = 1 and ov_active = 1: stay in IDLE; tr_wait_cnt increments, saturating at 255.
    - Otherwise stay in IDLE.
  - ACK:
    - tr_ack = 1 for exactly this cycle; return to IDLE unconditionally.
    - tr_req is ignored in this cycle, even if high and even if the address changed.
    - No wait counting in ACK.
- Handshake rules:
  - Requester holds tr_req, tr_col and tr_row stable from assertion until the tr_ack cycle.
  - Back-to-back throughput is one read per 2 cycles; a request left high after ack is re-granted in the next IDLE cycle.
  - Latency is 1 cycle from the grant edge to tr_ack / tr_val.
  - tr_val holds its value until the next grant.
  - tr_ack is driven by a register (FSM state), not decoded combinationally from inputs.
- tr_wait_cnt clears only on reset.
- Address widths exactly cover the map, so there is no out-of-range case. Column/row indexing wraps naturally and never aliases.

Test Plan:
- Reset then sweep ov_col/ov_row over all 256 cells -> ov_val = 1 on every border cell (e.g. (0,5), (15,15)); ov_val = 0 at (7,7).
- wr_en with (3,4) = 2; same cycle ov at (3,4) -> ov_val = 0 that cycle and 2 the next cycle.
- ov_active = 0, tr_req at (0,0) -> tr_ack high exactly 1 cycle after the grant edge, tr_val = 1. Keep tr_req high -> second ack 2 cycles after the first; ack pulses are never adjacent.
- ov_active = 1 for 10 cycles with tr_req at (7,7) after writing 3 there -> no ack for 10 cycles; tr_wait_cnt = 10. Drop ov_active -> ack next cycle with tr_val = 3.
- Hold ov_active = 1 and tr_req = 1 for 300 cycles -> tr_wait_cnt stops at 255.
- Grant at (2,2) with a same-cycle write of 3 to (2,2), then pull rst_n low in the ACK cycle:
  - tr_val = 0 (old value) at ack.
  - Async reset drops tr_ack immediately; tr_val = 0; cell (2,2) reads 0 again.
